// File: rtl/change_payout_controller.sv
// change_payout_controller: greedy 10/5/1 coin hopper payout sequencer with inventory tracking
module change_payout_controller #(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int INV_INIT10 = 20,
  parameter int INV_INIT5 = 20,
  parameter int INV_INIT1 = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [7:0] req_amount,
  output logic       req_ready,
  input  logic       coin_sensed,
  input  logic       refill_valid,
  input  logic [1:0] refill_sel,
  input  logic [7:0] refill_count,
  input  logic       fault_clr,
  output logic       eject10,
  output logic       eject5,
  output logic       eject1,
  output logic       done,
  output logic [7:0] shortfall,
  output logic       fault,
  output logic       busy,
  output logic [7:0] inv10,
  output logic [7:0] inv5,
  output logic [7:0] inv1
);
  typedef enum logic [2:0] {IDLE, SELECT, EJECT, WAIT_SENSE, GAP, DONE, FAULT} state_t;
  state_t state, state_n;
  logic [7:0] remaining, coin_val;
  logic [7:0] inv [3];
  logic [7:0] inv_n [3];
  logic [9:0] inv_sum [3];
  logic [1:0] sel, sel_n, esel;
  logic [15:0] timer;
  logic avail, last, sensed;
  always_comb begin
    avail = (remaining >= 8'd10 && inv[0] != 8'd0) || (remaining >= 8'd5 && inv[1] != 8'd0) || (remaining != 8'd0 && inv[2] != 8'd0);
    sel_n = (remaining >= 8'd10 && inv[0] != 8'd0) ? 2'd0 : (remaining >= 8'd5 && inv[1] != 8'd0) ? 2'd1 : 2'd2;
    esel = state == SELECT ? sel_n : sel;
    coin_val = sel == 2'd0 ? 8'd10 : sel == 2'd1 ? 8'd5 : 8'd1;
    sensed = state == WAIT_SENSE && coin_sensed;
    last = timer == 16'((state == EJECT ? PULSE_CYCLES : state == GAP ? GAP_CYCLES : TIMEOUT_CYCLES) - 1);
    for (int k = 0; k < 3; k++) begin
      inv_sum[k] = {2'b0, inv[k]} + (refill_valid && refill_sel == 2'(k) ? {2'b0, refill_count} : 10'd0) - (sensed && sel == 2'(k) ? 10'd1 : 10'd0);
      inv_n[k] = inv_sum[k] > 10'd255 ? 8'hff : inv_sum[k][7:0];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:       state_n = req_valid ? (req_amount == 8'd0 ? DONE : SELECT) : IDLE;
      SELECT:     state_n = avail ? EJECT : DONE;
      EJECT:      state_n = last ? WAIT_SENSE : EJECT;
      WAIT_SENSE: state_n = coin_sensed ? GAP : last ? FAULT : WAIT_SENSE;
      GAP:        state_n = last ? (remaining == 8'd0 ? DONE : SELECT) : GAP;
      DONE:       state_n = IDLE;
      FAULT:      state_n = fault_clr ? IDLE : FAULT;
      default:    state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      remaining <= 8'd0;
      sel <= 2'd0;
      timer <= 16'd0;
      inv[0] <= 8'(INV_INIT10);
      inv[1] <= 8'(INV_INIT5);
      inv[2] <= 8'(INV_INIT1);
      {eject10, eject5, eject1} <= 3'b000;
    end else begin
      timer <= state_n == state ? timer + 16'd1 : 16'd0;
      remaining <= state == IDLE && req_valid ? req_amount : sensed ? remaining - coin_val : state == FAULT && fault_clr ? 8'd0 : remaining;
      if (state == SELECT) sel <= sel_n;
      for (int k = 0; k < 3; k++) inv[k] <= inv_n[k];
      eject10 <= state_n == EJECT && esel == 2'd0;
      eject5 <= state_n == EJECT && esel == 2'd1;
      eject1 <= state_n == EJECT && esel == 2'd2;
    end
  end
  always_comb begin
    req_ready = state == IDLE;
    busy = state != IDLE;
    done = state == DONE;
    fault = state == FAULT;
    shortfall = (state == DONE || state == FAULT) ? remaining : 8'd0;
    inv10 = inv[0];
    inv5 = inv[1];
    inv1 = inv[2];
  end
endmodule
